// File: rtl/width_packer_pkg.sv
// Shared types and helpers for the width_packer narrow-to-wide stream gearbox.
package packer_pkg;

  typedef enum logic {
    LANE_LSB_FIRST = 1'b0,
    LANE_MSB_FIRST = 1'b1
  } lane_order_e;

  localparam int unsigned TIMEOUT_CYC_DEF = 1024;

  // Bit offset of lane k inside the output word for the given lane order.
  function automatic int unsigned lane_off(input int unsigned k,
                                           input lane_order_e ord,
                                           input int unsigned win,
                                           input int unsigned wout);
    if (ord == LANE_MSB_FIRST) return wout - (k + 1) * win;
    else                       return k * win;
  endfunction

endpackage

// File: rtl/width_packer_if.sv
// Stream bundle for width_packer: narrow input beats and wide output words.
interface width_packer_if #(
  parameter int unsigned DATAW_IN  = 8,
  parameter int unsigned DATAW_OUT = 32
);
  localparam int unsigned RATIO = DATAW_OUT / DATAW_IN;
  localparam int unsigned CNT_W = $clog2(RATIO + 1);

  logic                 in_valid;
  logic                 in_ready;
  logic [DATAW_IN-1:0]  in_data;
  logic                 in_last;
  logic                 msb_first;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATAW_OUT-1:0] out_data;
  logic [CNT_W-1:0]     out_count;
  logic                 out_last;

  modport slave (
    input  in_valid, in_data, in_last, msb_first, out_ready,
    output in_ready, out_valid, out_data, out_count, out_last
  );

  modport master (
    output in_valid, in_data, in_last, msb_first, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_last
  );
endinterface

// File: rtl/width_packer_slot.sv
// pack_slot: single-entry output register; loads when empty or draining, holds otherwise.
module pack_slot #(
  parameter int unsigned W  = 32,
  parameter int unsigned CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_valid_i,
  output logic          ld_ready_o,
  input  logic [W-1:0]  ld_data_i,
  input  logic [CW-1:0] ld_count_i,
  input  logic          ld_last_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [W-1:0]  out_data_o,
  output logic [CW-1:0] out_count_o,
  output logic          out_last_o
);
  logic          valid_q;
  logic [W-1:0]  data_q;
  logic [CW-1:0] count_q;
  logic          last_q;

  assign ld_ready_o = !valid_q || out_ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      count_q <= '0;
      last_q  <= 1'b0;
    end else if (ld_valid_i && ld_ready_o) begin
      valid_q <= 1'b1;
      data_q  <= ld_data_i;
      count_q <= ld_count_i;
      last_q  <= ld_last_i;
    end else if (out_ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_count_o = count_q;
  assign out_last_o  = last_q;
endmodule

// File: rtl/width_packer.sv
// width_packer: packs DATAW_IN beats into DATAW_OUT words; define PACKER_TIMEOUT_EN
// to auto-flush partial words after TIMEOUT_CYC idle cycles.
module width_packer
  import packer_pkg::*;
#(
  parameter int unsigned DATAW_IN    = 8,
  parameter int unsigned DATAW_OUT   = 32,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input logic          clk,
  input logic          rst,
  width_packer_if.slave bus_io
);
  localparam int unsigned RATIO = DATAW_OUT / DATAW_IN;
  localparam int unsigned CNT_W = $clog2(RATIO + 1);

  logic [DATAW_OUT-1:0] acc_q;
  logic [CNT_W-1:0]     cnt_q;
  lane_order_e          order_q;
  logic                 pend_q;
  logic [CNT_W-1:0]     pend_cnt_q;
  logic                 pend_last_q;

  logic                 accept, complete, timeout_fire, ld_ready;
  lane_order_e          order_cur;
  logic [DATAW_OUT-1:0] word_new;
  logic [CNT_W-1:0]     fill_cnt;
  logic                 fill_last;
  logic                 ld_valid;
  logic [DATAW_OUT-1:0] ld_data;
  logic [CNT_W-1:0]     ld_count;
  logic                 ld_last;

  assign accept          = bus_io.in_valid && !pend_q;
  assign bus_io.in_ready = !pend_q;

  always_comb begin
    order_cur = (cnt_q == '0) ? lane_order_e'(bus_io.msb_first) : order_q;
    word_new  = (cnt_q == '0) ? '0 : acc_q;
    word_new  = word_new |
                (DATAW_OUT'(bus_io.in_data) << lane_off(32'(cnt_q), order_cur, DATAW_IN, DATAW_OUT));
    complete  = accept && (bus_io.in_last || (cnt_q == CNT_W'(RATIO - 1)));
    fill_cnt  = timeout_fire ? cnt_q : cnt_q + CNT_W'(1);
    fill_last = !timeout_fire && bus_io.in_last;
    ld_valid  = pend_q || complete || timeout_fire;
    ld_data   = (pend_q || timeout_fire) ? acc_q : word_new;
    ld_count  = pend_q ? pend_cnt_q : fill_cnt;
    ld_last   = pend_q ? pend_last_q : fill_last;
  end

  // A completed word that finds the slot busy stays in acc_q; pend_q blocks new beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      order_q     <= LANE_LSB_FIRST;
      pend_q      <= 1'b0;
      pend_cnt_q  <= '0;
      pend_last_q <= 1'b0;
    end else begin
      if (pend_q && ld_ready) pend_q <= 1'b0;
      if (accept) begin
        acc_q <= word_new;
        if (cnt_q == '0) order_q <= order_cur;
        cnt_q <= complete ? '0 : cnt_q + CNT_W'(1);
      end
      if (timeout_fire) cnt_q <= '0;
      if ((complete || timeout_fire) && !ld_ready) begin
        pend_q      <= 1'b1;
        pend_cnt_q  <= fill_cnt;
        pend_last_q <= fill_last;
      end
    end
  end

`ifdef PACKER_TIMEOUT_EN
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYC + 1);
  logic [IDLE_W-1:0] idle_q;
  logic              idle_run;

  assign idle_run     = (cnt_q != '0) && !pend_q && !accept;
  assign timeout_fire = idle_run && (idle_q == IDLE_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst || !idle_run || timeout_fire) idle_q <= '0;
    else                                  idle_q <= idle_q + IDLE_W'(1);
  end
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT_CYC);
  assign timeout_fire   = 1'b0;
`endif

  pack_slot #(
    .W  (DATAW_OUT),
    .CW (CNT_W)
  ) u_slot (
    .clk         (clk),
    .rst         (rst),
    .ld_valid_i  (ld_valid),
    .ld_ready_o  (ld_ready),
    .ld_data_i   (ld_data),
    .ld_count_i  (ld_count),
    .ld_last_i   (ld_last),
    .out_valid_o (bus_io.out_valid),
    .out_ready_i (bus_io.out_ready),
    .out_data_o  (bus_io.out_data),
    .out_count_o (bus_io.out_count),
    .out_last_o  (bus_io.out_last)
  );
endmodule

// File: tb/tb_width_packer.sv
// Directed self-checking bench for width_packer (8->32); honours PACKER_TIMEOUT_EN.
module tb_width_packer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passes = 0;

  typedef struct {
    logic [31:0] d;
    logic [2:0]  c;
    logic        l;
  } word_t;
  word_t got[$];

  always #5 clk = ~clk;

  width_packer_if #(.DATAW_IN(8), .DATAW_OUT(32)) bus ();

  width_packer #(
    .DATAW_IN    (8),
    .DATAW_OUT   (32),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  always @(negedge clk)
    if (!rst && bus.out_valid && bus.out_ready)
      got.push_back('{d: bus.out_data, c: bus.out_count, l: bus.out_last});

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Presents one beat and returns just after the edge that accepts it.
  task automatic send_beat(input logic [7:0] d, input logic l, input logic m);
    int n = 0;
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_last   = l;
    bus.msb_first = m;
    while (!bus.in_ready && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (bus.in_ready !== 1'b1) $display("FAIL send_beat_timeout data %h in_ready %b want 1", d, bus.in_ready);
    else passes++;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    bus.in_data   = '0;
    bus.msb_first = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) tick();
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", bus.out_valid); else passes++;
    checks++; if (bus.out_data !== 32'h0) $display("FAIL reset_out_data got %h want 0", bus.out_data); else passes++;
    checks++; if (bus.out_count !== 3'd0) $display("FAIL reset_out_count got %0d want 0", bus.out_count); else passes++;
    checks++; if (bus.out_last !== 1'b0) $display("FAIL reset_out_last got %b want 0", bus.out_last); else passes++;
    checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", bus.in_ready); else passes++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_msb_first();
    got.delete();
    bus.out_ready = 1'b1;
    send_beat(8'h11, 1'b0, 1'b1);
    send_beat(8'h22, 1'b0, 1'b1);
    send_beat(8'h33, 1'b0, 1'b1);
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL msb_early_valid got %b want 0", bus.out_valid); else passes++;
    send_beat(8'h44, 1'b0, 1'b1);
    idle();
    checks++; if (bus.out_valid !== 1'b1) $display("FAIL msb_valid got %b want 1", bus.out_valid); else passes++;
    checks++; if (bus.out_data !== 32'h11223344) $display("FAIL msb_data got %h want 11223344", bus.out_data); else passes++;
    checks++; if (bus.out_count !== 3'd4) $display("FAIL msb_count got %0d want 4", bus.out_count); else passes++;
    checks++; if (bus.out_last !== 1'b0) $display("FAIL msb_last got %b want 0", bus.out_last); else passes++;
    repeat (3) tick();
    checks++; if (got.size() !== 1) $display("FAIL msb_words got %0d want 1", got.size()); else passes++;
  endtask

  task automatic test_lsb_first();
    got.delete();
    send_beat(8'h11, 1'b0, 1'b0);
    send_beat(8'h22, 1'b0, 1'b1);
    send_beat(8'h33, 1'b0, 1'b0);
    send_beat(8'h44, 1'b0, 1'b1);
    idle();
    checks++; if (bus.out_valid !== 1'b1) $display("FAIL lsb_valid got %b want 1", bus.out_valid); else passes++;
    checks++; if (bus.out_data !== 32'h44332211) $display("FAIL lsb_data got %h want 44332211", bus.out_data); else passes++;
    checks++; if (bus.out_count !== 3'd4) $display("FAIL lsb_count got %0d want 4", bus.out_count); else passes++;
    repeat (3) tick();
  endtask

  task automatic test_last();
    got.delete();
    send_beat(8'hAA, 1'b0, 1'b1);
    send_beat(8'hBB, 1'b1, 1'b1);
    idle();
    checks++; if (bus.out_data !== 32'hAABB0000) $display("FAIL last_data got %h want aabb0000", bus.out_data); else passes++;
    checks++; if (bus.out_count !== 3'd2) $display("FAIL last_count got %0d want 2", bus.out_count); else passes++;
    checks++; if (bus.out_last !== 1'b1) $display("FAIL last_flag got %b want 1", bus.out_last); else passes++;
    repeat (3) tick();
    checks++; if (got.size() !== 1) $display("FAIL last_words got %0d want 1", got.size()); else passes++;
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_d[3];
    exp_d[0] = 32'h01020304;
    exp_d[1] = 32'h05060708;
    exp_d[2] = 32'h090A0B0C;
    got.delete();
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) send_beat(8'(i), 1'b0, 1'b1);
    bus.in_data = 8'h09;
    checks++; if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready got %b want 0", bus.in_ready); else passes++;
    repeat (3) tick();
    checks++; if (bus.out_valid !== 1'b1) $display("FAIL bp_hold_valid got %b want 1", bus.out_valid); else passes++;
    checks++; if (bus.out_data !== exp_d[0]) $display("FAIL bp_hold_data got %h want %h", bus.out_data, exp_d[0]); else passes++;
    checks++; if (bus.out_count !== 3'd4) $display("FAIL bp_hold_count got %0d want 4", bus.out_count); else passes++;
    checks++; if (bus.in_ready !== 1'b0) $display("FAIL bp_stall_in_ready got %b want 0", bus.in_ready); else passes++;
    bus.out_ready = 1'b1;
    for (int i = 9; i <= 12; i++) send_beat(8'(i), 1'b0, 1'b1);
    idle();
    repeat (4) tick();
    checks++; if (got.size() !== 3) $display("FAIL bp_words got %0d want 3", got.size()); else passes++;
    for (int i = 0; i < 3; i++) begin
      if (i < got.size()) begin
        checks++; if (got[i].d !== exp_d[i]) $display("FAIL bp_word%0d got %h want %h", i, got[i].d, exp_d[i]); else passes++;
        checks++; if (got[i].c !== 3'd4) $display("FAIL bp_count%0d got %0d want 4", i, got[i].c); else passes++;
      end
    end
  endtask

  task automatic test_timeout();
    got.delete();
    bus.out_ready = 1'b1;
    send_beat(8'h01, 1'b0, 1'b1);
    send_beat(8'h02, 1'b0, 1'b1);
    send_beat(8'h03, 1'b0, 1'b1);
    idle();
    repeat (15) tick();
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL to_early_valid got %b want 0", bus.out_valid); else passes++;
    tick();
`ifdef PACKER_TIMEOUT_EN
    checks++; if (bus.out_valid !== 1'b1) $display("FAIL to_valid got %b want 1", bus.out_valid); else passes++;
    checks++; if (bus.out_data !== 32'h01020300) $display("FAIL to_data got %h want 01020300", bus.out_data); else passes++;
    checks++; if (bus.out_count !== 3'd3) $display("FAIL to_count got %0d want 3", bus.out_count); else passes++;
    checks++; if (bus.out_last !== 1'b0) $display("FAIL to_last got %b want 0", bus.out_last); else passes++;
    repeat (20) tick();
    checks++; if (got.size() !== 1) $display("FAIL to_words got %0d want 1", got.size()); else passes++;
`else
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL to_valid got %b want 0", bus.out_valid); else passes++;
    repeat (20) tick();
    checks++; if (got.size() !== 0) $display("FAIL to_words got %0d want 0", got.size()); else passes++;
`endif
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    got.delete();
    bus.out_ready = 1'b1;
    send_beat(8'h01, 1'b0, 1'b1);
    send_beat(8'h02, 1'b0, 1'b1);
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    send_beat(8'h05, 1'b0, 1'b1);
    send_beat(8'h06, 1'b0, 1'b1);
    send_beat(8'h07, 1'b0, 1'b1);
    send_beat(8'h08, 1'b0, 1'b1);
    idle();
    repeat (4) tick();
    checks++; if (got.size() !== 1) $display("FAIL rstmid_words got %0d want 1", got.size()); else passes++;
    if (got.size() > 0) begin
      checks++; if (got[0].d !== 32'h05060708) $display("FAIL rstmid_data got %h want 05060708", got[0].d); else passes++;
      checks++; if (got[0].c !== 3'd4) $display("FAIL rstmid_count got %0d want 4", got[0].c); else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_last();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/width_packer.md
# width_packer

Streaming narrow-to-wide packer: assembles DATAW_IN-bit beats into DATAW_OUT-bit words with valid/ready handshakes on both sides, per-word selectable lane order, and partial-word emission on end-of-packet.
- Successor to the fixed 8-to-32 concatenator on the UART/loader receive path; also serves as a generic gearbox into memory-write and instruction-fetch paths.
- Sustains one input beat per cycle under full throughput.

## Interface
- DATAW_IN, 8, input beat width
- DATAW_OUT, 32, output word width; must be an integer multiple of DATAW_IN, ratio ≥ 2
- RATIO, DATAW_OUT/DATAW_IN, lanes per word (derived)
- CNT_W, $clog2(RATIO+1), width of lane count
- TIMEOUT_CYC, 1024, idle cycles before auto-flush (used only with macro)
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset: synchronous, active-high
- in_valid  in  1  input beat present
- in_ready  out  1  packer accepts beat this cycle
- in_data  in  DATAW_IN  beat payload
- in_last  in  1  beat ends packet; completes current word
- msb_first  in  1  lane order, sampled on the first beat of each word
- out_valid  out  1  output word present
- out_ready  in  1  consumer accepts word
- out_data  out  DATAW_OUT  packed word, unfilled lanes zero
- out_count  out  CNT_W  filled lanes, 1..RATIO
- out_last  out  1  word closed by in_last

## Operation
- Beat accepted iff in_valid && in_ready; word delivered iff out_valid && out_ready.
- Accumulator state: lane counter acc_cnt (0..RATIO-1), latched order bit, pend flag.
- Lane placement for the k-th accepted beat of a word (k from 0):
  - msb_first=1: bits [DATAW_OUT-1-k*DATAW_IN -: DATAW_IN] (first beat in the MSBs).
  - msb_first=0: bits [k*DATAW_IN +: DATAW_IN].
- Lanes are cleared to zero when a word starts.
- Word completes on the accepted beat with k == RATIO-1 or with in_last=1.
  - out_count = k+1.
  - out_last = in_last of that beat.
- Transfer of a completed word to the output slot:
  - Moves into the slot on the same edge if the slot is empty or is being drained this cycle.
  - Otherwise pend=1 and the word waits in the accumulator.
  - While pend=1, in_ready=0; pend clears on the edge the slot frees.
- in_ready = !pend.
- No empty words: in_last always accompanies a data beat.

## Timing
- Reset values: out_valid=0, out_data=0, out_count=0, out_last=0, in_ready=1, acc_cnt=0, pend=0.
- Latency: out_valid rises in the cycle after the completing beat is accepted, when the slot is free.
- Throughput: with out_ready held 1, one word per RATIO cycles and no in_ready bubbles.
- out_data, out_count and out_last stay stable while out_valid && !out_ready.
- out_valid never drops without a delivery.
- Simultaneous slot drain and new completed word: the new word loads on the same edge, so out_valid stays 1.
- Reset mid-word or with pend=1: all partial and pending data is discarded with no output.
- msb_first changes mid-word have no effect until the next word.

## Configuration
- PACKER_TIMEOUT_EN defined: auto-flush via an idle counter.
  - Counter runs while acc_cnt ≥ 1, pend=0 and no beat is accepted.
  - After TIMEOUT_CYC consecutive idle cycles, the partial word completes with out_count=acc_cnt and out_last=0.
  - A beat accepted in the timeout cycle wins: the beat joins the word and the counter resets.
- Undefined: no counter; partial words complete only via in_last.

## Structure
- packer_pkg holds:
  - lane-order enum (LANE_LSB_FIRST, LANE_MSB_FIRST);
  - function computing lane bit offset from (k, order, DATAW_IN, DATAW_OUT);
  - constant default TIMEOUT_CYC.
- One sub-module, pack_slot: single-entry output register with valid/ready load/drain logic and data hold.
- Accumulator, lane counter and timeout logic stay in width_packer.

## Test plan
- 8→32, msb_first=1, beats 11,22,33,44 back-to-back, out_ready=1 → out_data=0x11223344, count=4, last=0, out_valid one cycle after beat 4.
- Same beats, msb_first=0 → out_data=0x44332211.
- Beats AA,BB with in_last on BB, msb_first=1 → out_data=0xAABB0000, count=2, last=1.
- out_ready=0, 12 beats offered continuously:
  - word 1 held stable in the slot;
  - in_ready drops after beat 8;
  - after out_ready=1, words 1, 2, 3 delivered in order with no loss or duplication.
- With PACKER_TIMEOUT_EN and TIMEOUT_CYC=16: beats 01,02,03 then idle → word 0x01020300, count=3 after 16 idle cycles; without the macro no output.
- Beats 01,02, rst for 1 cycle, then 05,06,07,08 → exactly one word, 0x05060708.
